// File: rtl/grey_bcd_pkg.sv
// Shared types and helpers for the Gray-to-BCD decoder.
// bcd_digits sizes the packed BCD output for a given binary width.
package grey_bcd_pkg;

  typedef enum logic [1:0] {IDLE, GREY, DABBLE, DONE} dec_state_t;

  localparam logic [3:0] BCD_ADD3 = 4'd3;

  function automatic int bcd_digits(input int w);
    int v;
    int n;
    v = (1 << w) - 1;
    n = 0;
    while (v > 0) begin
      n++;
      v = v / 10;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble step: every BCD nibble >= 5 gets +3, then the whole scratch shifts left.
// Purely combinational; binary field sits in the low WIDTH bits, digits above it.
module bcd_dabble_step
  import grey_bcd_pkg::*;
#(
  parameter int NDIG  = 3,
  parameter int WIDTH = 8
) (
  input  logic [4*NDIG+WIDTH-1:0] i_scr,
  output logic [4*NDIG+WIDTH-1:0] o_scr
);

  logic [4*NDIG+WIDTH-1:0] w_add;

  always_comb begin
    w_add = i_scr;
    for (int k = 0; k < NDIG; k++) begin
      if (i_scr[WIDTH+4*k +: 4] >= 4'd5) begin
        w_add[WIDTH+4*k +: 4] = i_scr[WIDTH+4*k +: 4] + BCD_ADD3;
      end
    end
    o_scr = w_add << 1;
  end

endmodule

// File: rtl/grey_to_bcd_decoder.sv
// Bit-serial Gray -> binary -> packed BCD decoder, one word in flight, valid/ready on both sides.
// out_valid rises 2*WIDTH+1 edges after accept; result is held until out_ready.
module grey_to_bcd_decoder
  import grey_bcd_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int MAX_VAL = 2**WIDTH - 1,
  localparam int NDIG    = bcd_digits(WIDTH)
) (
  input  logic                CLK100MHZ,
  input  logic                CPU_RESETN,
  input  logic [WIDTH-1:0]    grey_in,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    bin_out,
  output logic [4*NDIG-1:0]   bcd_out,
  output logic                out_err,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int SW = 4*NDIG + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  dec_state_t            r_state;
  dec_state_t            w_next;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH-1:0]      r_grey;
  logic [WIDTH-1:0]      r_bin;
  logic [SW-1:0]         r_scr;
  logic [SW-1:0]         w_scr_nxt;
  logic [WIDTH-1:0]      r_bin_out;
  logic [4*NDIG-1:0]     r_bcd_out;
  logic                  r_err;
  logic                  w_bin_bit;
  logic                  w_last_grey;
  logic                  w_dab_done;

  // r_grey is consumed MSB first; r_bin[0] is always the previously resolved bit.
  assign w_bin_bit   = r_bin[0] ^ r_grey[WIDTH-1];
  assign w_last_grey = (r_cnt == CW'(WIDTH - 1));
  assign w_dab_done  = (r_cnt == CW'(WIDTH));

  assign in_ready  = (r_state == IDLE) && CPU_RESETN;
  assign out_valid = (r_state == DONE);
  assign bin_out   = r_bin_out;
  assign bcd_out   = r_bcd_out;
  assign out_err   = r_err;

  bcd_dabble_step #(
    .NDIG  (NDIG),
    .WIDTH (WIDTH)
  ) u_step (
    .i_scr (r_scr),
    .o_scr (w_scr_nxt)
  );

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)    w_next = GREY;
      GREY:    if (w_last_grey) w_next = DABBLE;
      DABBLE:  if (w_dab_done)  w_next = DONE;
      DONE:    if (out_ready)   w_next = IDLE;
      default:                  w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (!CPU_RESETN) begin
      r_cnt     <= '0;
      r_grey    <= '0;
      r_bin     <= '0;
      r_scr     <= '0;
      r_bin_out <= '0;
      r_bcd_out <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_grey <= grey_in;
            r_bin  <= '0;
            r_cnt  <= '0;
          end
        end
        GREY: begin
          r_grey <= r_grey << 1;
          r_bin  <= {r_bin[WIDTH-2:0], w_bin_bit};
          if (w_last_grey) begin
            r_cnt <= '0;
            r_scr <= {{(4*NDIG){1'b0}}, r_bin[WIDTH-2:0], w_bin_bit};
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DABBLE: begin
          // WIDTH shift steps, then one extra edge to publish the result.
          if (w_dab_done) begin
            r_bin_out <= r_bin;
            r_bcd_out <= r_scr[SW-1 -: 4*NDIG];
            r_err     <= (int'(r_bin) > MAX_VAL);
          end else begin
            r_scr <= w_scr_nxt;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
